// File: rtl/tu_chain_sched.sv
// ---------------------------------------------------------------------------
// tu_chain_sched
//   Hands a single pass token to a chain of test units (TU0..TU(NUM_TU-1)),
//   one unit at a time. It waits for the holder's to_down_pass, applies a
//   per-unit timeout, and records which units timed out. It also records
//   whether the run was cut short by abort.
//
// Ports
//   clock         in   rising-edge clock for all logic
//   rst           in   synchronous, active-high reset
//   start         in   1-cycle pulse; begins a run when the sequencer is idle
//   abort         in   level; ends the current run (sampled in RUN/GAP only)
//   tu_up_pass    out  one-hot token to TU[i].from_up_pass, or all zero
//   tu_down_pass  in   TU[i].to_down_pass; only the holder's bit is looked at
//   busy          out  a run is in progress (RUN, GAP or FIN)
//   done          out  1-cycle pulse at the end of every run
//   cur_idx       out  index of the unit holding (or last holding) the token
//   timeout_mask  out  bit i set when TU i timed out during the last run
//   aborted       out  the last run was ended by abort
// ---------------------------------------------------------------------------
module tu_chain_sched #(
    parameter int NUM_TU    = 4,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 1000,
    localparam int IDX_W    = (NUM_TU > 1) ? $clog2(NUM_TU) : 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [NUM_TU-1:0] tu_up_pass,
    input  logic [NUM_TU-1:0] tu_down_pass,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx,
    output logic [NUM_TU-1:0] timeout_mask,
    output logic              aborted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FIN
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_TU - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [NUM_TU-1:0]   mask_q, mask_d;
    logic                aborted_q, aborted_d;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        aborted_d = aborted_q;

        case (state_q)
            ST_IDLE: begin
                // Result flags from the previous run stay visible until a new
                // run is actually accepted.
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    cnt_d     = '0;
                    mask_d    = '0;
                    aborted_d = 1'b0;
                end
            end

            ST_RUN: begin
                // Priority: abort, then completion, then timeout. A unit that
                // answers on its very last allowed cycle is not timed out.
                if (abort) begin
                    state_d   = ST_FIN;
                    aborted_d = 1'b1;
                    cnt_d     = '0;
                end else if (tu_down_pass[idx_q]) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    mask_d[idx_q] = 1'b1;
                    state_d       = ST_GAP;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end

            ST_GAP: begin
                // One token-free cycle so the finished unit can release its
                // to_down_pass before the next unit is handed the token.
                cnt_d = '0;
                if (abort) begin
                    state_d   = ST_FIN;
                    aborted_d = 1'b1;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RUN;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so they change only on
    // clock edges.
    always_comb begin
        tu_up_pass = '0;
        if (state_q == ST_RUN) begin
            tu_up_pass = NUM_TU'(1) << idx_q;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);
    assign cur_idx      = idx_q;
    assign timeout_mask = mask_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_tu_chain_sched.sv
// ---------------------------------------------------------------------------
// tb_tu_chain_sched
//   Directed bench for tu_chain_sched (NUM_TU=4, TIMEOUT=20). For each run the
//   bench builds the expected token schedule from the per-unit response delays:
//   unit i gets the token at s_i and holds it for min(k_i+1, TIMEOUT) cycles.
//   One gap cycle follows, then the next unit starts. The done cycle,
//   the final masks and a few token counts are also pinned by hand-computed
//   literals. Cycle n is the interval after the n-th rising edge of the run.
//   Outputs are sampled and inputs are driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_tu_chain_sched;

    localparam int N    = 4;
    localparam int TO   = 20;
    localparam int MAXC = 128;

    logic         clock = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [N-1:0] tu_up_pass;
    logic [N-1:0] tu_down_pass;
    logic         busy;
    logic         done;
    logic [1:0]   cur_idx;
    logic [N-1:0] timeout_mask;
    logic         aborted;

    always #5 clock = ~clock;

    tu_chain_sched #(
        .NUM_TU   (N),
        .TIMEOUT_W(16),
        .TIMEOUT  (TO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tu_up_pass  (tu_up_pass),
        .tu_down_pass(tu_down_pass),
        .busy        (busy),
        .done        (done),
        .cur_idx     (cur_idx),
        .timeout_mask(timeout_mask),
        .aborted     (aborted)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus and expected schedule for one run, indexed by cycle.
    logic         st_start [MAXC];
    logic         st_abort [MAXC];
    logic [N-1:0] st_down  [MAXC];
    logic [N-1:0] e_up     [MAXC];
    int           e_idx    [MAXC];
    int           m_fin;
    logic [N-1:0] m_mask;
    logic         m_abort;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // k = cycles after the token rises at which the unit raises to_down_pass;
    // k < 0 means the unit never answers.
    task automatic build(input int k0, input int k1, input int k2, input int k3,
                         input int abort_at);
        int k [N];
        int t, s, hold, last_idx;
        bit tout;
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        for (int c = 0; c < MAXC; c++) begin
            st_start[c] = 1'b0;
            st_abort[c] = 1'b0;
            st_down[c]  = '0;
            e_up[c]     = '0;
            e_idx[c]    = 0;
        end
        st_start[0] = 1'b1;
        m_mask  = '0;
        m_abort = 1'b0;
        t = 1;
        for (int i = 0; i < N; i++) begin
            s    = t;
            tout = !(k[i] >= 0 && k[i] + 1 <= TO);
            hold = tout ? TO : k[i] + 1;
            for (int c = s; c < s + hold; c++) begin
                e_up[c]  = N'(1) << i;
                e_idx[c] = i;
            end
            if (k[i] >= 0) st_down[s + k[i]][i] = 1'b1;
            if (tout && (abort_at < 0 || s + hold - 1 < abort_at)) m_mask[i] = 1'b1;
            e_idx[s + hold] = i;
            t = s + hold + 1;
        end
        m_fin = t;
        last_idx = N - 1;
        if (abort_at >= 1 && abort_at < m_fin) begin
            m_fin    = abort_at + 1;
            m_abort  = 1'b1;
            last_idx = e_idx[abort_at];
            st_abort[abort_at] = 1'b1;
            for (int c = m_fin; c < MAXC; c++) begin
                e_up[c]    = '0;
                st_down[c] = '0;
            end
        end
        for (int c = m_fin; c < MAXC; c++) e_idx[c] = last_idx;
        e_idx[0] = -1;
    endtask

    task automatic run_scn(input string nm, input int k0, input int k1, input int k2,
                           input int k3, input int abort_at, input bit spur,
                           input int lit_fin, input logic [N-1:0] lit_mask,
                           input logic lit_ab, input int lit_tu2);
        int dut_fin = -1;
        int tu2_cyc = 0;
        build(k0, k1, k2, k3, abort_at);
        if (spur) begin
            // start/abort together in IDLE, start while busy, abort in FIN,
            // and a stray completion from a unit not holding the token.
            st_abort[0]     = 1'b1;
            st_start[3]     = 1'b1;
            st_start[10]    = 1'b1;
            st_start[m_fin] = 1'b1;
            st_abort[m_fin] = 1'b1;
            st_down[3][3]   = 1'b1;
        end
        for (int n = 0; n <= m_fin + 3; n++) begin
            @(negedge clock);
            chk($sformatf("%s/up c%0d", nm, n), 32'(tu_up_pass), 32'(e_up[n]));
            chk($sformatf("%s/busy c%0d", nm, n), 32'(busy), 32'((n >= 1 && n <= m_fin) ? 1 : 0));
            chk($sformatf("%s/done c%0d", nm, n), 32'(done), 32'((n == m_fin) ? 1 : 0));
            if (e_idx[n] >= 0) chk($sformatf("%s/idx c%0d", nm, n), 32'(cur_idx), 32'(e_idx[n]));
            if (n == 1) begin
                chk($sformatf("%s/mask_clr", nm), 32'(timeout_mask), 32'h0);
                chk($sformatf("%s/abort_clr", nm), 32'(aborted), 32'h0);
            end
            if (n >= m_fin) begin
                chk($sformatf("%s/mask c%0d", nm, n), 32'(timeout_mask), 32'(m_mask));
                chk($sformatf("%s/aborted c%0d", nm, n), 32'(aborted), 32'(m_abort));
            end
            if (done === 1'b1 && dut_fin < 0) dut_fin = n;
            if (tu_up_pass[2] === 1'b1) tu2_cyc++;
            start        = st_start[n];
            abort        = st_abort[n];
            tu_down_pass = st_down[n];
        end
        @(negedge clock);
        start        = 1'b0;
        abort        = 1'b0;
        tu_down_pass = '0;
        chk({nm, "/done_cycle"}, 32'(dut_fin), 32'(lit_fin));
        chk({nm, "/final_mask"}, 32'(timeout_mask), 32'(lit_mask));
        chk({nm, "/final_aborted"}, 32'(aborted), 32'(lit_ab));
        chk({nm, "/tu2_token_cycles"}, 32'(tu2_cyc), 32'(lit_tu2));
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "/up"}, 32'(tu_up_pass), 32'h0);
        chk({nm, "/busy"}, 32'(busy), 32'h0);
        chk({nm, "/done"}, 32'(done), 32'h0);
        chk({nm, "/idx"}, 32'(cur_idx), 32'h0);
        chk({nm, "/mask"}, 32'(timeout_mask), 32'h0);
        chk({nm, "/aborted"}, 32'(aborted), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        tu_down_pass = '0;
        repeat (3) @(negedge clock);
        chk_reset_state("por");
        rst = 1'b0;
        @(negedge clock);

        // Each unit answers 5 cycles after its token: 4*5 + 2*4 + 1 = 29.
        run_scn("normal", 5, 5, 5, 5, -1, 1'b0, 29, 4'b0000, 1'b0, 6);
        // TU2 silent: holds the token exactly TIMEOUT cycles, TU3 still runs.
        run_scn("timeout", 5, 5, -1, 5, -1, 1'b0, 43, 4'b0100, 1'b0, 20);
        // TU1 answers on its last allowed cycle: completion beats timeout.
        run_scn("race_last", 5, 19, 5, 5, -1, 1'b0, 43, 4'b0000, 1'b0, 6);
        // TU1 answers one cycle too late: already timed out, answer ignored.
        run_scn("late_by_one", 5, 20, 5, 5, -1, 1'b0, 43, 4'b0010, 1'b0, 6);
        // Abort on the same cycle TU0 completes: abort wins, TU1 never runs.
        run_scn("abort_race", 5, 5, 5, 5, 6, 1'b0, 7, 4'b0000, 1'b1, 0);
        // Abort during the gap after TU1.
        run_scn("abort_gap", 5, 5, 5, 5, 14, 1'b0, 15, 4'b0000, 1'b1, 0);
        // Spurious start/abort/down activity: identical to the normal run.
        run_scn("spurious", 5, 5, 5, 5, -1, 1'b1, 29, 4'b0000, 1'b0, 6);

        // Reset mid-run after TU0 has timed out (mask bit 0 set at cycle 21).
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (23) @(negedge clock);
        chk("rst_mid/pre_mask", 32'(timeout_mask), 32'h1);
        chk("rst_mid/pre_busy", 32'(busy), 32'h1);
        chk("rst_mid/pre_up", 32'(tu_up_pass), 32'h2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_reset_state($sformatf("rst_mid%0d", i));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("post_rst/done%0d", i), 32'(done), 32'h0);
            chk($sformatf("post_rst/busy%0d", i), 32'(busy), 32'h0);
            chk($sformatf("post_rst/up%0d", i), 32'(tu_up_pass), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
